pop_uart_tx: RTL and testbench



---
 rtl/pop_uart_tx_if.sv | 13 +
 rtl/pop_uart_tx.sv | 112 +++++++++++
 tb/tb_pop_uart_tx.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pop_uart_tx_if.sv
// Request/status bundle between the GA state controller and the UART frame transmitter.
interface pop_uart_tx_if #(
   parameter int unsigned DATA_W = 150
);
   logic              start;
   logic [DATA_W-1:0] data;
   logic              busy;
   logic              done;
   logic              uart_out;

   modport master (output start, output data, input busy, input done, input uart_out);
   modport slave  (input start, input data, output busy, output done, output uart_out);
endinterface

// File: rtl/pop_uart_tx.sv
// Serialises a captured population/path vector as SYNC_BYTE followed by NBYTES payload
// bytes (LSB byte first) on an 8N1 UART line, with no idle gap between bytes.
module pop_uart_tx #(
   parameter int unsigned DATA_W       = 150,
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic          clk,
   input  logic          rst_n,
   pop_uart_tx_if.slave  tx_if
);
   localparam int unsigned NBYTES = (DATA_W + 7) / 8;
   localparam int unsigned BUF_W  = NBYTES * 8;
   localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned IDX_W  = $clog2(NBYTES + 1);
   localparam logic [CNT_W-1:0] BaudLast = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IdxLast  = IDX_W'(NBYTES);

   typedef enum logic [1:0] {StIdle, StStartBit, StDataBits, StStopBit} state_e;

   state_e           state_q;
   logic [CNT_W-1:0] baud_q;
   logic [2:0]       bit_q;
   logic [IDX_W-1:0] byte_q;
   logic [7:0]       shift_q;
   logic [BUF_W-1:0] buf_q;
   logic             busy_q;
   logic             done_q;
   logic             tx_q;
   logic             baud_end;

   assign baud_end = (baud_q == BaudLast);

   // buf_q shifts down one byte per loaded byte, so the next payload byte is always buf_q[7:0].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         shift_q <= '0;
         buf_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (tx_if.start) begin
                  buf_q   <= BUF_W'(tx_if.data);
                  shift_q <= SYNC_BYTE;
                  byte_q  <= '0;
                  bit_q   <= '0;
                  baud_q  <= '0;
                  busy_q  <= 1'b1;
                  tx_q    <= 1'b0;
                  state_q <= StStartBit;
               end
            end
            StStartBit: begin
               if (baud_end) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  tx_q    <= shift_q[0];
                  state_q <= StDataBits;
               end else begin
                  baud_q <= baud_q + CNT_W'(1);
               end
            end
            StDataBits: begin
               if (baud_end) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= StStopBit;
                  end else begin
                     shift_q <= shift_q >> 1;
                     tx_q    <= shift_q[1];
                     bit_q   <= bit_q + 3'd1;
                  end
               end else begin
                  baud_q <= baud_q + CNT_W'(1);
               end
            end
            StStopBit: begin
               if (baud_end) begin
                  baud_q <= '0;
                  if (byte_q == IdxLast) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= StIdle;
                  end else begin
                     shift_q <= buf_q[7:0];
                     buf_q   <= buf_q >> 8;
                     byte_q  <= byte_q + IDX_W'(1);
                     tx_q    <= 1'b0;
                     state_q <= StStartBit;
                  end
               end else begin
                  baud_q <= baud_q + CNT_W'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign tx_if.busy     = busy_q;
   assign tx_if.done     = done_q;
   assign tx_if.uart_out = tx_q;
endmodule

// File: tb/tb_pop_uart_tx.sv
// Scoreboard bench: two transmitters (12-bit and 150-bit payloads) whose serial lines are
// decoded bit-by-bit and compared against frames predicted from the data words.
module tb_pop_uart_tx;
   localparam int CPB   = 4;
   localparam int NB12  = 2;
   localparam int NB150 = 19;
   localparam int L12   = (NB12 + 1) * 10 * CPB;
   localparam int L150  = (NB150 + 1) * 10 * CPB;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   int   edge_no = 0;
   int   idle_from [2];
   int   nacc [2];
   int   nabort = 0;
   int   dn12 = 0;
   int   dn150 = 0;
   logic [159:0] q12 [$];
   logic [159:0] q150 [$];

   pop_uart_tx_if #(.DATA_W(12))  if12 ();
   pop_uart_tx_if #(.DATA_W(150)) if150 ();

   pop_uart_tx #(.DATA_W(12), .CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) u_dut12 (
      .clk   (clk),
      .rst_n (rst_n),
      .tx_if (if12.slave)
   );

   pop_uart_tx #(.DATA_W(150), .CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) u_dut150 (
      .clk   (clk),
      .rst_n (rst_n),
      .tx_if (if150.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_no <= edge_no + 1;

   always @(negedge clk) begin
      if (if12.done === 1'b1)  dn12  <= dn12 + 1;
      if (if150.done === 1'b1) dn150 <= dn150 + 1;
   end

   task automatic check(input string name, input logic [159:0] got, input logic [159:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h at t=%0t", name, got, want, $time);
      end
   endtask

   function automatic logic line_of(input int w);
      return (w == 0) ? if12.uart_out : if150.uart_out;
   endfunction

   function automatic logic busy_of(input int w);
      return (w == 0) ? if12.busy : if150.busy;
   endfunction

   function automatic logic done_of(input int w);
      return (w == 0) ? if12.done : if150.done;
   endfunction

   function automatic logic [159:0] rnd160();
      return {$urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Called at a negedge; model: a start is taken only once the previous frame has completed.
   task automatic pulse(input int w, input logic [159:0] d);
      int           nxt;
      logic [159:0] m;
      nxt = edge_no + 1;
      if (w == 0) begin
         if12.start = 1'b1;
         if12.data  = d[11:0];
      end else begin
         if150.start = 1'b1;
         if150.data  = d[149:0];
      end
      if (nxt >= idle_from[w]) begin
         m = (w == 0) ? (d & ((160'd1 << 12) - 160'd1)) : (d & ((160'd1 << 150) - 160'd1));
         if (w == 0) q12.push_back(m);
         else q150.push_back(m);
         idle_from[w] = nxt + ((w == 0) ? L12 : L150) + 1;
         nacc[w]++;
      end
      @(negedge clk);
      if (w == 0) begin
         if12.start = 1'b0;
         if12.data  = 12'($urandom);
      end else begin
         if150.start = 1'b0;
         if150.data  = rnd160()[149:0];
      end
   endtask

   task automatic wait_idle(input int w);
      while (edge_no < idle_from[w] + 2) @(negedge clk);
      @(negedge clk);
   endtask

   task automatic monitor(input int w);
      int           nb;
      logic [159:0] exp, sh;
      logic [7:0]   got, want;
      logic         v, lv;
      bit           bad, aborted, first;
      nb = (w == 0) ? NB12 : NB150;
      @(negedge clk);
      forever begin
         while (!(rst_n === 1'b1 && line_of(w) === 1'b0)) @(negedge clk);
         exp = '0;
         if (w == 0) begin
            if (q12.size() == 0) check("unexpected_frame_w0", 1, 0);
            else exp = q12.pop_front();
         end else begin
            if (q150.size() == 0) check("unexpected_frame_w1", 1, 0);
            else exp = q150.pop_front();
         end
         aborted = 1'b0;
         first   = 1'b1;
         for (int b = 0; b <= nb && !aborted; b++) begin
            if (b == 0) begin
               want = 8'hA5;
            end else begin
               sh   = exp >> (8 * (b - 1));
               want = sh[7:0];
            end
            bad = 1'b0;
            got = '0;
            lv  = 1'b0;
            for (int j = 0; j < 10 && !aborted; j++) begin
               for (int c = 0; c < CPB && !aborted; c++) begin
                  if (!first) @(negedge clk);
                  first = 1'b0;
                  if (rst_n !== 1'b1) begin
                     aborted = 1'b1;
                  end else begin
                     v = line_of(w);
                     if (busy_of(w) !== 1'b1 || done_of(w) !== 1'b0) bad = 1'b1;
                     if (c == 0) lv = v;
                     else if (v !== lv) bad = 1'b1;
                     if (j == 0 && v !== 1'b0) bad = 1'b1;
                     if (j == 9 && v !== 1'b1) bad = 1'b1;
                     if (j >= 1 && j <= 8 && c == 0) got[j-1] = v;
                  end
               end
            end
            if (!aborted) begin
               check($sformatf("w%0d_byte%0d", w, b), got, want);
               check($sformatf("w%0d_bit_timing_byte%0d", w, b), bad, 0);
            end
         end
         if (!aborted) begin
            @(negedge clk);
            check($sformatf("w%0d_done_busy_line", w), {done_of(w), busy_of(w), line_of(w)}, 3'b101);
            @(negedge clk);
            check($sformatf("w%0d_done_width", w), done_of(w), 0);
         end
      end
   endtask

   initial monitor(0);
   initial monitor(1);

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      bit bad;
      int e;
      rst_n = 1'b0;
      if12.start = 1'b0;
      if12.data = '0;
      if150.start = 1'b0;
      if150.data = '0;
      idle_from = '{0, 0};
      nacc = '{0, 0};
      repeat (3) @(negedge clk);
      check("reset_outputs", {if12.uart_out, if12.busy, if12.done,
                              if150.uart_out, if150.busy, if150.done}, 6'b100100);
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if ({if12.uart_out, if12.busy, if12.done} !== 3'b100) bad = 1'b1;
         if ({if150.uart_out, if150.busy, if150.done} !== 3'b100) bad = 1'b1;
      end
      check("idle_50_cycles", bad, 0);

      pulse(0, 160'hABC);
      wait_idle(0);

      pulse(1, {160{1'b1}});
      wait_idle(1);

      // Second start lands mid-frame and must be dropped.
      pulse(0, 160'h123);
      repeat (38) @(negedge clk);
      pulse(0, 160'hFFF);
      wait_idle(0);

      pulse(0, rnd160());
      while (edge_no + 1 < idle_from[0]) @(negedge clk);
      check("b2b_done_cycle", if12.done, 1);
      pulse(0, 160'h055);
      check("b2b_next_cycle_start", {if12.uart_out, if12.busy}, 2'b01);
      wait_idle(0);

      pulse(1, rnd160());
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(0, 150)) @(negedge clk);
         pulse(0, rnd160());
      end
      wait_idle(0);
      wait_idle(1);

      // Abort during a payload data bit of an all-zero byte so the line is low beforehand.
      pulse(0, 160'h0);
      e = idle_from[0] - L12 - 1;
      while (edge_no < e + 13 * CPB) @(negedge clk);
      #1;
      check("abort_line_low_before", if12.uart_out, 0);
      rst_n = 1'b0;
      #1;
      check("abort_async_outputs", {if12.uart_out, if12.busy, if12.done}, 3'b100);
      nabort++;
      idle_from = '{0, 0};
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      pulse(0, rnd160());
      wait_idle(0);
      repeat (3) @(negedge clk);

      check("w0_frames_left", q12.size(), 0);
      check("w1_frames_left", q150.size(), 0);
      check("w0_done_count", dn12, nacc[0] - nabort);
      check("w1_done_count", dn150, nacc[1]);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
